// File: rtl/axi_pw_bit_cfg_arb.sv
// Round-robin AXI write sequencer that shares the axi_pw_bit register port among NUM_OUTPUTS
// channel requesters. It issues one AW, then W, then B at a time and reports failed responses.
module axi_pw_bit_cfg_arb #(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 8,
  parameter int unsigned NUM_OUTPUTS    = 4,
  parameter int unsigned REGS_PER_CH    = 8,
  parameter int unsigned B_TIMEOUT      = 64,
  localparam int unsigned CH_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
  localparam int unsigned REG_W = (REGS_PER_CH > 1) ? $clog2(REGS_PER_CH) : 1
) (
  input  logic                            aclk,
  input  logic                            areset,

  input  logic [NUM_OUTPUTS-1:0]          req_valid,
  output logic [NUM_OUTPUTS-1:0]          req_ready,
  input  logic [NUM_OUTPUTS*REG_W-1:0]    req_reg,
  input  logic [NUM_OUTPUTS*AXI_DATA_WIDTH-1:0] req_data,

  output logic                            busy,
  output logic                            err_valid,
  output logic [CH_W-1:0]                 err_ch,
  output logic [1:0]                      err_resp,

  output logic [AXI_ID_WIDTH-1:0]         m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]       m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]       m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]     m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]         m_axi_bid,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  localparam int unsigned CNT_W = $clog2(B_TIMEOUT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAw   = 2'd1;
  localparam logic [1:0] StW    = 2'd2;
  localparam logic [1:0] StB    = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [CH_W-1:0]           ptr_q, ptr_d;
  logic [CH_W-1:0]           gnt_q, gnt_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_valid_q, err_valid_d;
  logic [CH_W-1:0]           err_ch_q, err_ch_d;
  logic [1:0]                err_resp_q, err_resp_d;

  logic                      gnt_found;
  logic [CH_W-1:0]           gnt_idx;
  logic [REG_W-1:0]          sel_reg;
  logic [AXI_DATA_WIDTH-1:0] sel_data;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [NUM_OUTPUTS-1:0]    rdy_c;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      unused_bid;

  assign unused_bid = ^m_axi_bid;

  // First requester at or above the pointer, wrapping modulo NUM_OUTPUTS.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      cand = 32'(ptr_q) + 32'(k);
      if (cand >= NUM_OUTPUTS) begin
        cand = cand - NUM_OUTPUTS;
      end
      if (!gnt_found && req_valid[CH_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(cand);
      end
    end
  end

  always_comb begin
    sel_reg  = req_reg[32'(gnt_idx) * REG_W +: REG_W];
    sel_data = req_data[32'(gnt_idx) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    sel_addr = AXI_ADDR_WIDTH'((32'(gnt_idx) * REGS_PER_CH + 32'(sel_reg)) * 4);
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_valid_d = 1'b0;
    err_ch_d    = err_ch_q;
    err_resp_d  = err_resp_q;
    rdy_c       = '0;

    case (state_q)
      StIdle: begin
        if (gnt_found) begin
          rdy_c[gnt_idx] = 1'b1;
          gnt_d          = gnt_idx;
          addr_d         = sel_addr;
          data_d         = sel_data;
          ptr_d          = (gnt_idx == CH_W'(NUM_OUTPUTS - 1)) ? '0 : gnt_idx + CH_W'(1);
          state_d        = StAw;
        end
      end
      StAw: begin
        if (m_axi_awready) begin
          state_d = StW;
        end
      end
      StW: begin
        if (m_axi_wready) begin
          state_d = StB;
          cnt_d   = '0;
        end
      end
      StB: begin
        if (m_axi_bvalid) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (m_axi_bresp != 2'b00) begin
            err_valid_d = 1'b1;
            err_ch_d    = gnt_q;
            err_resp_d  = m_axi_bresp;
          end
        end else if (32'(cnt_inc) == B_TIMEOUT) begin
          cnt_d       = '0;
          state_d     = StIdle;
          err_valid_d = 1'b1;
          err_ch_d    = gnt_q;
          err_resp_d  = 2'b11;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_ch_q    <= '0;
      err_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      err_valid_q <= err_valid_d;
      err_ch_q    <= err_ch_d;
      err_resp_q  <= err_resp_d;
    end
  end

  // Reset is asynchronous, so the accept pulse must not leak out while it is held.
  assign req_ready     = areset ? '0 : rdy_c;
  assign busy          = (state_q != StIdle);
  assign err_valid     = err_valid_q;
  assign err_ch        = err_ch_q;
  assign err_resp      = err_resp_q;

  assign m_axi_awid    = '0;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = (state_q == StAw);
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == StW);
  assign m_axi_bready  = (state_q == StB);

  a_aw_w_exclusive : assert property (@(posedge aclk) disable iff (areset)
    !(m_axi_awvalid && m_axi_wvalid));
  a_ready_onehot : assert property (@(posedge aclk) disable iff (areset)
    $onehot0(req_ready));
  a_aw_stable : assert property (@(posedge aclk) disable iff (areset)
    (m_axi_awvalid && !m_axi_awready) |=> (m_axi_awvalid && $stable(m_axi_awaddr)));

endmodule

// File: tb/tb_axi_pw_bit_cfg_arb.sv
// Scoreboard bench for axi_pw_bit_cfg_arb: directed requests push expected grants, writes and
// errors; a monitor pops and compares whenever the DUT presents a handshake or an error pulse.
module tb_axi_pw_bit_cfg_arb;

  logic        aclk;
  logic        areset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_reg;
  logic [127:0] req_data;
  logic        busy;
  logic        err_valid;
  logic [1:0]  err_ch;
  logic [1:0]  err_resp;
  logic [0:0]  awid;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_pw_bit_cfg_arb dut (
    .aclk          (aclk),
    .areset        (areset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .busy          (busy),
    .err_valid     (err_valid),
    .err_ch        (err_ch),
    .err_resp      (err_resp),
    .m_axi_awid    (awid),
    .m_axi_awaddr  (awaddr),
    .m_axi_awprot  (awprot),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bid     (bid),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  assign bid = 1'b0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  int   gq[$];
  wr_t  wq[$];
  logic [3:0] eq[$];

  int vec;
  int miss;

  // Slave configuration, written only by the stimulus process.
  int         aw_delay;
  int         w_delay;
  bit         b_never;
  logic [1:0] resp_for_ch[4];
  int         late_cnt;

  // Monitor observations used by stimulus-side timing checks.
  int cyc;
  int last_gap;
  int last_aw_len;
  int last_w_len;
  int last_err_lat;

  int left[4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_wr(input int ch, input logic [7:0] a, input logic [31:0] d);
    gq.push_back(ch);
    wq.push_back({a, d});
  endtask

  task automatic post(input int ch, input logic [2:0] r, input logic [31:0] d, input int n);
    req_reg[ch*3 +: 3]   = r;
    req_data[ch*32 +: 32] = d;
    left[ch]             = n;
    req_valid[ch]        = 1'b1;
  endtask

  // One clock; a requester drops its valid once its last write has been accepted.
  task automatic step();
    logic [3:0] gr;
    @(negedge aclk);
    gr = req_ready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (gr[i] && left[i] > 0) begin
        left[i] = left[i] - 1;
        if (left[i] == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input string name, input int budget);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      step();
      n++;
      if (left[0] == 0 && left[1] == 0 && left[2] == 0 && left[3] == 0 && !busy) ok = 1'b1;
    end
    check({name, "_done"}, 64'(ok), 64'd1);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    areset    = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) left[i] = 0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  // Slave: readies after a configurable number of wait cycles, per-channel bresp.
  initial begin : slave
    int         aw_cnt;
    int         w_cnt;
    int         late_done;
    logic [1:0] s_ch;
    aw_cnt = 0; w_cnt = 0; late_done = 0; s_ch = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(posedge aclk);
      #1;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      if (areset) begin
        aw_cnt = 0;
        w_cnt  = 0;
      end else begin
        if (awvalid) begin
          if (aw_cnt >= aw_delay) begin
            awready = 1'b1;
            aw_cnt  = 0;
            s_ch    = awaddr[6:5];
          end else aw_cnt++;
        end
        if (wvalid) begin
          if (w_cnt >= w_delay) begin
            wready = 1'b1;
            w_cnt  = 0;
          end else w_cnt++;
        end
        if (bready && !b_never) begin
          bvalid = 1'b1;
          bresp  = resp_for_ch[s_ch];
        end else if (late_cnt != late_done) begin
          bvalid = 1'b1;
          bresp  = 2'b10;
          late_done++;
        end
      end
    end
  end

  initial begin : monitor
    int         g;
    int         aw_run;
    int         w_run;
    int         last_gcyc;
    int         b_start;
    bit         prev_awv;
    bit         prev_wv;
    bit         prev_br;
    logic [7:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [31:0] exp_wdata;
    wr_t        e;
    logic [3:0] ee;
    aw_run = 0; w_run = 0; last_gcyc = 0; b_start = 0;
    prev_awv = 0; prev_wv = 0; prev_br = 0;
    prev_addr = '0; prev_wdata = '0; exp_wdata = '0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (areset) begin
        aw_run = 0; w_run = 0; prev_awv = 0; prev_wv = 0; prev_br = 0;
      end else begin
        if (req_ready != '0) begin
          g = -1;
          for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
          check("grant_onehot", 64'($countones(req_ready)), 64'd1);
          last_gap  = cyc - last_gcyc;
          last_gcyc = cyc;
          if (gq.size() == 0) check("grant_unexpected", 64'(g), 64'hFF);
          else check("grant_ch", 64'(g), 64'(gq.pop_front()));
        end
        if (awvalid) begin
          aw_run++;
          if (prev_awv) check("aw_addr_stable", 64'(awaddr), 64'(prev_addr));
        end
        if (awvalid && awready) begin
          if (wq.size() == 0) check("aw_unexpected", 64'(awaddr), 64'hFFFF);
          else begin
            e = wq.pop_front();
            check("aw_addr", 64'(awaddr), 64'(e.addr));
            check("aw_wdata", 64'(wdata), 64'(e.data));
            exp_wdata = e.data;
          end
          check("aw_wstrb_wvalid", 64'({wstrb, wvalid}), 64'({4'hF, 1'b0}));
          last_aw_len = aw_run;
          aw_run      = 0;
        end
        if (wvalid) begin
          w_run++;
          if (prev_wv) check("w_data_stable", 64'(wdata), 64'(prev_wdata));
        end
        if (wvalid && wready) begin
          check("w_data", 64'({awvalid, wdata}), 64'({1'b0, exp_wdata}));
          last_w_len = w_run;
          w_run      = 0;
        end
        if (bready && !prev_br) b_start = cyc;
        if (err_valid) begin
          last_err_lat = cyc - b_start;
          if (eq.size() == 0) check("err_unexpected", 64'({err_ch, err_resp}), 64'hFF);
          else begin
            ee = eq.pop_front();
            check("err_ch_resp", 64'({err_ch, err_resp}), 64'(ee));
          end
        end
        prev_awv   = awvalid;
        prev_wv    = wvalid;
        prev_br    = bready;
        prev_addr  = awaddr;
        prev_wdata = wdata;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miss);
    $fatal(1);
  end

  initial begin : stim
    int n;
    vec = 0; miss = 0; cyc = 0;
    last_gap = 0; last_aw_len = 0; last_w_len = 0; last_err_lat = 0;
    aw_delay = 0; w_delay = 0; b_never = 1'b0; late_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      resp_for_ch[i] = 2'b00;
      left[i]        = 0;
    end
    areset    = 1'b1;
    req_valid = 4'hF;
    req_reg   = '0;
    req_data  = '0;

    // Reset state, with requests pending to show no accept pulse escapes.
    repeat (2) @(negedge aclk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_status", 64'({busy, err_valid, err_ch, err_resp}), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, bready}), 64'd0);
    check("rst_aw", 64'({awid, awprot, awaddr}), 64'd0);
    check("rst_w", 64'({wstrb, wdata}), 64'({4'hF, 32'd0}));
    req_valid = '0;
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Basic write.
    expect_wr(1, 8'h2C, 32'd15);
    post(1, 3'd3, 32'd15, 1);
    run("basic", 50);
    check("basic_busy_low", 64'(busy), 64'd0);

    // Round-robin from a fresh pointer; channel 0 asks twice.
    apply_reset();
    for (int i = 0; i < 4; i++) expect_wr(i, 8'(i * 32), 32'(60 + i));
    expect_wr(0, 8'h00, 32'd60);
    for (int i = 0; i < 4; i++) post(i, 3'd0, 32'(60 + i), (i == 0) ? 2 : 1);
    run("rr", 100);
    check("rr_grant_gap", 64'(last_gap), 64'd4);

    // Backpressure on AW and W.
    aw_delay = 5;
    w_delay  = 3;
    expect_wr(3, 8'h74, 32'hDEADBEEF);
    post(3, 3'd5, 32'hDEADBEEF, 1);
    run("bp", 100);
    check("bp_aw_len", 64'(last_aw_len), 64'd6);
    check("bp_w_len", 64'(last_w_len), 64'd4);
    aw_delay = 0;
    w_delay  = 0;

    // Slave error on channel 2, channel 3 follows.
    resp_for_ch[2] = 2'b10;
    expect_wr(2, 8'h44, 32'h1234);
    expect_wr(3, 8'h7C, 32'h5678);
    eq.push_back({2'd2, 2'b10});
    post(2, 3'd1, 32'h1234, 1);
    post(3, 3'd7, 32'h5678, 1);
    run("slverr", 100);
    resp_for_ch[2] = 2'b00;

    // Timeout, then a stray bvalid in IDLE, then a normal write.
    b_never = 1'b1;
    expect_wr(0, 8'h08, 32'hA5A5A5A5);
    eq.push_back({2'd0, 2'b11});
    post(0, 3'd2, 32'hA5A5A5A5, 1);
    run("timeout", 200);
    check("timeout_latency", 64'(last_err_lat), 64'd64);
    b_never  = 1'b0;
    late_cnt = late_cnt + 1;
    repeat (3) @(posedge aclk);
    #1;
    expect_wr(1, 8'h38, 32'd77);
    post(1, 3'd6, 32'd77, 1);
    run("after_late_b", 50);

    // Reset while in W: abandoned write, pointer back to 0.
    w_delay = 10;
    expect_wr(2, 8'h40, 32'd99);
    post(2, 3'd0, 32'd99, 1);
    n = 0;
    while (!wvalid && n < 20) begin
      step();
      n++;
    end
    check("mid_reached_w", 64'(wvalid), 64'd1);
    #2;
    areset = 1'b1;
    #1;
    check("mid_valids_drop", 64'({awvalid, wvalid, bready, busy}), 64'd0);
    check("mid_no_pulses", 64'({req_ready, err_valid}), 64'd0);
    repeat (2) @(negedge aclk);
    areset  = 1'b0;
    w_delay = 0;
    @(posedge aclk);
    #1;
    expect_wr(0, 8'h04, 32'd5);
    expect_wr(3, 8'h64, 32'd6);
    post(0, 3'd1, 32'd5, 1);
    post(3, 3'd1, 32'd6, 1);
    run("after_mid_reset", 50);

    check("grants_left", 64'(gq.size()), 64'd0);
    check("writes_left", 64'(wq.size()), 64'd0);
    check("errors_left", 64'(eq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/axi_pw_bit_cfg_arb.md
Name: axi_pw_bit_cfg_arb

Overview:
- Single-master AXI write sequencer that shares the axi_pw_bit register port among NUM_OUTPUTS local requesters, one per PWM channel.
- Each requester posts single register writes (register index plus data). The block arbitrates round-robin, issues one AXI write (AW, then W, then B), and reports failed or timed-out responses.
- Sits between channel-level control logic and the s_axi write port of axi_pw_bit.
- Read channels are not driven by this block.

Parameters:
- AXI_ID_WIDTH, 1, width of awid/bid.
- AXI_DATA_WIDTH, 32, data width; fixed at 32.
- AXI_ADDR_WIDTH, 8, address width; must be at least clog2(NUM_OUTPUTS*REGS_PER_CH)+2.
- NUM_OUTPUTS, 4, number of requesters/channels.
- REGS_PER_CH, 8, registers per channel block; power of 2.
- B_TIMEOUT, 64, cycles to wait for bvalid before abandoning the transaction; must be at least 1.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_OUTPUTS  per-channel write request.
- req_ready  out  NUM_OUTPUTS  one-cycle accept pulse per channel.
- req_reg  in  NUM_OUTPUTS*clog2(REGS_PER_CH)  register index; channel i occupies slice i.
- req_data  in  NUM_OUTPUTS*32  write data; channel i occupies slice i.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_valid  out  1  one-cycle pulse reporting a failed write.
- err_ch  out  clog2(NUM_OUTPUTS)  channel of the failed write.
- err_resp  out  2  captured bresp; 2'b11 on timeout.
- m_axi_awid  out  AXI_ID_WIDTH  constant 0.
- m_axi_awaddr  out  AXI_ADDR_WIDTH  write address.
- m_axi_awprot  out  3  constant 0.
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  constant 4'hF.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bid  in  AXI_ID_WIDTH  ignored.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.

Behaviour:
- Reset (areset high, asynchronous):
  - all outputs 0 except m_axi_wstrb = 4'hF;
  - FSM in IDLE; round-robin pointer = 0; timeout counter = 0.
- FSM states are IDLE, AW, W, B.
- IDLE:
  - If any req_valid is high, grant the first set bit at or above the pointer, wrapping modulo NUM_OUTPUTS.
  - Pulse req_ready[g] for that one cycle.
  - Latch g, the address ((g*REGS_PER_CH + req_reg[g])*4), and the data.
  - Set pointer = (g+1) mod NUM_OUTPUTS, and go to AW.
  - With no request, stay in IDLE.
- AW:
  - m_axi_awvalid is 1, with awaddr and wdata stable.
  - On awready, drop awvalid and go to W (m_axi_wvalid = 1 from the next cycle).
- W:
  - m_axi_wvalid is 1.
  - On wready, drop wvalid and go to B.
  - AW and W are never asserted together.
- B:
  - m_axi_bready is 1; the counter increments each cycle.
  - On bvalid: if bresp != 2'b00, pulse err_valid with err_ch = g and err_resp = bresp. Go to IDLE.
  - If the counter reaches B_TIMEOUT with no bvalid: pulse err_valid with err_resp = 2'b11, clear the counter, go to IDLE.
  - A late bvalid arriving in IDLE is ignored, because bready is 0 there.
- Timing and latency:
  - The earliest awvalid is 1 cycle after the req_ready pulse.
  - With single-cycle slave readies, a write takes 4 cycles: IDLE, AW, W, B. The next grant follows in the next IDLE cycle.
- Requester contract:
  - req_reg and req_data are sampled only on the req_ready cycle.
  - A requester may hold req_valid high for back-to-back writes.
  - Deasserting req_valid before grant withdraws the request.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,N-1,0. No channel waits more than N-1 grants.
- Reset mid-transaction: awvalid, wvalid and bready drop immediately; the pending write is abandoned with no err_valid and no req_ready.
- Index range: req_reg is always in range (full-width field, REGS_PER_CH a power of 2), so no range check is needed.

Test Plan:
- Basic write: reset, then req_valid[1] with reg 3 and data 32'd15, slave ready always → one req_ready[1] pulse, awaddr 8'h2C, wdata 15, wstrb F, no err_valid, busy low after the B cycle.
- Round-robin: all four channels valid with reg 0 and data 32'd60+i → grants in order 0,1,2,3. awaddr sequence 0x00, 0x20, 0x40, 0x60, then channel 0 again if still valid.
- Backpressure: awready delayed 5 cycles and wready delayed 3 → awvalid held 6 cycles with a stable address. wvalid rises only after the AW handshake. wdata is unchanged throughout.
- Error path: the slave returns bresp 2'b10 on a channel 2 write → err_valid one cycle with err_ch 2 and err_resp 2'b10; the arbiter continues with the next requester.
- Timeout: bvalid never asserted, B_TIMEOUT=64 → err_valid with err_resp 2'b11 exactly 64 cycles after entering B. A later bvalid does not disturb the next transaction.
- Reset mid-transaction: areset asserted during the W state → wvalid drops asynchronously, there is no error pulse, the pointer returns to 0, and after release channel 0 is granted first.
